// File: rtl/shiftregister_seq_pkg.sv
// Shared types for the serial shift/rotate sequencer: command modes, FSM states
// and a helper that classifies modes executed one bit per clock.
package shiftregister_seq_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHL  = 3'b001,
      MODE_SHR  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROTL = 3'b100,
      MODE_ROTR = 3'b101,
      MODE_ASHR = 3'b110,
      MODE_RSVD = 3'b111
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for modes that take amount_i single-bit steps
   function automatic logic is_shift(input mode_t m);
      return (m == MODE_SHL)  || (m == MODE_SHR)  || (m == MODE_ROTL) ||
             (m == MODE_ROTR) || (m == MODE_ASHR);
   endfunction

endpackage

// File: rtl/shiftregister_step.sv
// One-bit shift/rotate step: pure combinational next-value function.
// Load, hold and reserved modes pass the value through unchanged.
module shiftregister_step
   import shiftregister_seq_pkg::*;
#(
   parameter int unsigned DATASIZE = 8
) (
   input  mode_t               mode_i,
   input  logic [DATASIZE-1:0] value_i,
   input  logic                ser_in_msb_i,
   input  logic                ser_in_lsb_i,
   output logic [DATASIZE-1:0] value_nxt_c
);

   always_comb begin
      value_nxt_c = value_i;
      case (mode_i)
         MODE_SHL:  value_nxt_c = {value_i[DATASIZE-2:0], ser_in_lsb_i};
         MODE_SHR:  value_nxt_c = {ser_in_msb_i, value_i[DATASIZE-1:1]};
         MODE_ROTL: value_nxt_c = {value_i[DATASIZE-2:0], value_i[DATASIZE-1]};
         MODE_ROTR: value_nxt_c = {value_i[0], value_i[DATASIZE-1:1]};
         MODE_ASHR: value_nxt_c = {value_i[DATASIZE-1], value_i[DATASIZE-1:1]};
         default:   value_nxt_c = value_i;
      endcase
   end

endmodule

// File: rtl/shiftregister_seq.sv
// Multi-bit shift/rotate sequencer, one bit per clock, start/busy/done handshake.
// Optional SHIFTREG_PARITY_EN adds a registered parity_o of value_o.
module shiftregister_seq
   import shiftregister_seq_pkg::*;
#(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned AMTSIZE  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [2:0]          mode_i,
   input  logic [AMTSIZE-1:0]  amount_i,
   input  logic [DATASIZE-1:0] load_value_i,
   input  logic                ser_in_msb_i,
   input  logic                ser_in_lsb_i,
   output logic [DATASIZE-1:0] value_o,
   output logic                busy_o,
   output logic                done_o
`ifdef SHIFTREG_PARITY_EN
   ,
   output logic                parity_o
`endif
);

   state_t              r_state;
   mode_t               r_mode;
   logic [AMTSIZE-1:0]  r_cnt;
   logic [DATASIZE-1:0] r_value;
   logic                r_busy;
   logic                r_done;

   state_t              w_state_nxt;
   mode_t               w_mode_nxt;
   mode_t               w_mode_in;
   mode_t               w_step_mode;
   logic [AMTSIZE-1:0]  w_cnt_nxt;
   logic [DATASIZE-1:0] w_value_nxt;
   logic [DATASIZE-1:0] w_step_value;

   assign w_mode_in   = mode_t'(mode_i);
   // The first step uses the incoming mode; later steps use the latched one
   assign w_step_mode = (r_state == IDLE) ? w_mode_in : r_mode;

   shiftregister_step #(
      .DATASIZE (DATASIZE)
   ) u_step (
      .mode_i       (w_step_mode),
      .value_i      (r_value),
      .ser_in_msb_i (ser_in_msb_i),
      .ser_in_lsb_i (ser_in_lsb_i),
      .value_nxt_c  (w_step_value)
   );

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_cnt_nxt   = r_cnt;
      w_value_nxt = r_value;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_mode_nxt  = w_mode_in;
               w_state_nxt = DONE;
               if (w_mode_in == MODE_LOAD) begin
                  w_value_nxt = load_value_i;
               end else if (is_shift(w_mode_in) && (amount_i != '0)) begin
                  w_value_nxt = w_step_value;
                  w_cnt_nxt   = amount_i - AMTSIZE'(1);
                  if (amount_i != AMTSIZE'(1)) begin
                     w_state_nxt = RUN;
                  end
               end
            end
         end
         RUN: begin
            w_value_nxt = w_step_value;
            if (r_cnt <= AMTSIZE'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - AMTSIZE'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_mode  <= MODE_HOLD;
         r_cnt   <= '0;
         r_value <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_cnt   <= w_cnt_nxt;
         r_value <= w_value_nxt;
         r_busy  <= (w_state_nxt == RUN);
         r_done  <= (w_state_nxt == DONE);
      end
   end

   assign value_o = r_value;
   assign busy_o  = r_busy;
   assign done_o  = r_done;

`ifdef SHIFTREG_PARITY_EN
   logic r_parity;

   // Parity tracks the value being registered so both update together
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= ^w_value_nxt;
      end
   end

   assign parity_o = r_parity;
`endif

endmodule

// File: doc/shiftregister_seq.md
Name: shiftregister_seq

Overview:
Parametrised successor of the team's 4-mode shift register. Executes multi-bit shift/rotate commands one bit per clock under a start/busy/done handshake, with logical, rotate and arithmetic modes. Sits between a control FSM and a data path needing serialised shifting. Also serves as a formal-verification target for property-based checks of each mode.

Parameters:
DATASIZE, 8, register width in bits (>=2)
AMTSIZE, 4, width of the shift-amount field; max amount = 2**AMTSIZE-1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  command strobe, accepted only when busy_o=0
mode_i  in  3  command mode (see Behaviour)
amount_i  in  AMTSIZE  number of 1-bit steps for shift/rotate modes
load_value_i  in  DATASIZE  parallel load data
ser_in_msb_i  in  1  serial bit entering MSB on logical shift right
ser_in_lsb_i  in  1  serial bit entering LSB on logical shift left
value_o  out  DATASIZE  register contents
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (rst_i=0, async): value_o=0, busy_o=0, done_o=0, FSM=IDLE, step counter=0.
- Modes: 000 hold; 001 shl (LSB<=ser_in_lsb_i); 010 shr (MSB<=ser_in_msb_i); 011 load; 100 rotl; 101 rotr; 110 ashr (MSB replicated); 111 reserved, treated as hold.
- FSM states IDLE, RUN, DONE.
- IDLE + start_i=1:
  - Mode and amount are latched.
  - load: value_o<=load_value_i at the same edge; go to DONE.
  - hold/reserved, or any shift mode with amount_i=0: value unchanged; go to DONE.
  - Shift modes with amount_i>0: apply the first step at the same edge; counter<=amount_i-1; go to DONE if the counter is 0, else RUN.
- RUN:
  - One step per cycle.
  - Serial inputs are sampled live each step, not latched.
  - Counter decrements each step; when the counter reaches 0 at a step, next state is DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0; next state is IDLE.
  - start_i in the DONE cycle is ignored.
  - Back-to-back commands therefore have a minimum spacing of 2 cycles.
- busy_o=1 exactly in RUN and in the acceptance cycle's successor states until DONE.
  - Precisely: busy_o=1 while state=RUN.
- Latency: command with amount N (N>=1) gives done_o at cycle N after the accepting edge; load/hold/amount 0 gives done_o at cycle 1.
- start_i while busy_o=1 or in DONE: ignored, with no effect on the latched command.
- value_o is stable in IDLE and DONE.
- Amount larger than DATASIZE is legal: rotates wrap modulo DATASIZE; shl/shr fill fully with serial bits; ashr saturates to all-sign.
- Reset mid-command: immediate abort, all outputs go to reset values, and no done_o pulse is produced.

Optional Feature:
Macro SHIFTREG_PARITY_EN.
- Defined: extra output parity_o (1 bit), registered, equal to XOR of the next value_o, so it is valid in the same cycle as value_o. Reset value 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Package shiftregister_seq_pkg holds:
  - typedef enum logic[2:0] mode_t (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_ASHR, MODE_RSVD)
  - typedef enum state_t (IDLE, RUN, DONE)
- One natural sub-module, shiftregister_step: purely combinational one-step next-value function (mode, value, ser_in_msb, ser_in_lsb -> next value). It is reused by the FSM and by the assertion model.

Test Plan:
- Reset then load 8'hA5 -> value_o=8'hA5 one cycle after start; done_o pulses at cycle 1; busy_o never 1.
- value=8'h81, rotl amount 3 -> busy_o high 2 cycles; done_o at cycle 3; value_o=8'h0C.
- value=8'h80, ashr amount 9 -> value_o=8'hFF; done at cycle 9. Then shr amount 2 with ser_in_msb_i=0 -> 8'h3F.
- value=8'h00, shl amount 4 with ser_in_lsb_i toggling 1,0,1,1 -> value_o=8'h0B.
- start_i pulsed during RUN with mode load 8'h55 -> ignored; original rotate result retained; single done_o pulse.
- rst_i asserted in the middle of a shr amount-10 command -> value_o=0 and busy_o=0 immediately; no done_o. A load after reset release works normally.
